reg_cmd_ctrl: RTL

- Command-level controller that sequences the 16x8 register file and the ALU from a byte stream delivered by the UART RX path.
- Decodes framed commands (register write, register read, ALU op with operands, ALU op without operands).
- Drives register file and ALU control signals, and pushes response bytes into the TX synchronous FIFO.
- Sits in the reference-clock domain between the RX data synchronizer and the TX FIFO write port.

---
 rtl/reg_cmd_ctrl_pkg.sv | 20 ++
 rtl/reg_cmd_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl_pkg.sv
`timescale 1ns/1ps
// reg_cmd_ctrl_pkg: command codes, operand register addresses and FSM state
// encoding shared by the command controller and anything that talks to it.
package reg_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // addr, data
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // addr
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // A, B, fun
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // fun

  // ALU operands live in fixed register file slots.
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OP_A, OP_B, ALU_FUNC, ALU_WAIT, TX_BYTE0, TX_BYTE1
  } state_e;

endpackage

// File: rtl/reg_cmd_ctrl.sv
`timescale 1ns/1ps
// reg_cmd_ctrl: decodes framed command bytes from the RX path, drives the
// register file and ALU, and pushes response bytes into the TX FIFO.
//   CLK/RST          reference clock, async active-low reset
//   RX_P_DATA/D_VLD  incoming byte + single-cycle strobe
//   RF_*             register file address/enables/write data, read return
//   ALU_*            ALU strobe/function, result return
//   CLK_GATE_EN      ALU clock-gate enable (high while an ALU op is pending)
//   FIFO_FULL        TX FIFO back-pressure
//   TX_P_DATA/D_VLD  byte + write strobe into the TX FIFO
// Every output comes straight from a flop.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDR      = 4,
  parameter int ALU_OUT_W = 16,
  parameter int FUN_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATAWIDTH-1:0] RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [ADDR-1:0]      RF_Address,
  output logic                 RF_WrEn,
  output logic                 RF_RdEn,
  output logic [DATAWIDTH-1:0] RF_WrData,
  input  logic [DATAWIDTH-1:0] RF_RdData,
  input  logic                 RF_RdData_Valid,
  output logic                 ALU_EN,
  output logic [FUN_W-1:0]     ALU_FUN,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  output logic                 CLK_GATE_EN,
  input  logic                 FIFO_FULL,
  output logic [DATAWIDTH-1:0] TX_P_DATA,
  output logic                 TX_D_VLD
);

  state_e                 state_q, state_d;
  logic                   two_byte_q, two_byte_d;  // ALU response: send MSB too
  logic [ALU_OUT_W-1:0]   result_q, result_d;
  logic [ADDR-1:0]        rf_addr_q, rf_addr_d;
  logic [DATAWIDTH-1:0]   rf_wrdata_q, rf_wrdata_d;
  logic                   rf_wren_q, rf_wren_d;
  logic                   rf_rden_q, rf_rden_d;
  logic                   alu_en_q, alu_en_d;
  logic [FUN_W-1:0]       alu_fun_q, alu_fun_d;
  logic                   clk_gate_q, clk_gate_d;
  logic [DATAWIDTH-1:0]   tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;

  always_comb begin
    state_d     = state_q;
    two_byte_d  = two_byte_q;
    result_d    = result_q;
    rf_addr_d   = rf_addr_q;
    rf_wrdata_d = rf_wrdata_q;
    rf_wren_d   = 1'b0;
    rf_rden_d   = 1'b0;
    alu_en_d    = 1'b0;
    alu_fun_d   = alu_fun_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = 1'b0;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_RF_WR:   state_d = WR_ADDR;
          CMD_RF_RD:   begin state_d = RD_ADDR;  two_byte_d = 1'b0; end
          CMD_ALU_OP:  begin state_d = OP_A;     two_byte_d = 1'b1; end
          CMD_ALU_NOP: begin state_d = ALU_FUNC; two_byte_d = 1'b1; end
          default:     ;  // unknown command byte: stay idle
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        rf_wren_d   = 1'b1;
        rf_wrdata_d = RX_P_DATA;
        state_d     = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rf_addr_d = RX_P_DATA[ADDR-1:0];
        rf_rden_d = 1'b1;
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (RF_RdData_Valid) begin
        result_d = ALU_OUT_W'(RF_RdData);
        state_d  = TX_BYTE0;
      end
      OP_A: if (RX_D_VLD) begin
        rf_addr_d   = ADDR'(OPA_ADDR);
        rf_wrdata_d = RX_P_DATA;
        rf_wren_d   = 1'b1;
        state_d     = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        rf_addr_d   = ADDR'(OPB_ADDR);
        rf_wrdata_d = RX_P_DATA;
        rf_wren_d   = 1'b1;
        state_d     = ALU_FUNC;
      end
      ALU_FUNC: if (RX_D_VLD) begin
        alu_en_d  = 1'b1;
        alu_fun_d = RX_P_DATA[FUN_W-1:0];
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        result_d = ALU_OUT;
        state_d  = TX_BYTE0;
      end
      TX_BYTE0: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[DATAWIDTH-1:0];
        state_d   = two_byte_q ? TX_BYTE1 : IDLE;
      end
      TX_BYTE1: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = result_q[2*DATAWIDTH-1:DATAWIDTH];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered from the next state so the gate tracks ALU_FUNC/ALU_WAIT
  // exactly while the FSM sits in them.
  assign clk_gate_d = (state_d == ALU_FUNC) || (state_d == ALU_WAIT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      two_byte_q  <= 1'b0;
      result_q    <= '0;
      rf_addr_q   <= '0;
      rf_wrdata_q <= '0;
      rf_wren_q   <= 1'b0;
      rf_rden_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      clk_gate_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      two_byte_q  <= two_byte_d;
      result_q    <= result_d;
      rf_addr_q   <= rf_addr_d;
      rf_wrdata_q <= rf_wrdata_d;
      rf_wren_q   <= rf_wren_d;
      rf_rden_q   <= rf_rden_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      clk_gate_q  <= clk_gate_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
    end
  end

  assign RF_Address  = rf_addr_q;
  assign RF_WrEn     = rf_wren_q;
  assign RF_RdEn     = rf_rden_q;
  assign RF_WrData   = rf_wrdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;

endmodule
